// File: rtl/async_fifo_rd_ctrl.sv
// Read-side controller for a dual-clock FIFO.
// Keeps the binary read pointer and exports it in Gray code to the write
// domain. Compares it against the synchronised Gray write pointer to produce
// registered empty, almost-empty, fill-level, data-valid and sticky
// underflow status.
module async_fifo_rd_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  R_CLK,
  input  logic                  R_RST,
  input  logic                  R_INC,
  input  logic                  R_UF_CLR,
  input  logic [ADDR_WIDTH:0]   rq2_wptr,
  output logic [ADDR_WIDTH-1:0] R_ADDR,
  output logic                  R_RD_EN,
  output logic [ADDR_WIDTH:0]   R_PTR,
  output logic                  R_EMPTY,
  output logic                  R_AEMPTY,
  output logic [ADDR_WIDTH:0]   R_LEVEL,
  output logic                  R_VALID,
  output logic                  R_UNDERFLOW
);

  localparam logic [ADDR_WIDTH:0] AE_TH = (ADDR_WIDTH+1)'(AE_LEVEL);

  logic [ADDR_WIDTH:0] r_rbin;
  logic [ADDR_WIDTH:0] r_ptr;
  logic                r_empty;
  logic                r_aempty;
  logic [ADDR_WIDTH:0] r_level;
  logic                r_valid;
  logic                r_underflow;

  logic                w_accept;
  logic [ADDR_WIDTH:0] w_rbin_next;
  logic [ADDR_WIDTH:0] w_gnext;
  logic [ADDR_WIDTH:0] w_wbin;
  logic [ADDR_WIDTH:0] w_level_next;

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] g);
    logic [ADDR_WIDTH:0] b;
    b = '0;
    for (int i = 0; i <= ADDR_WIDTH; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  // While reset is low r_empty is already 1, but the explicit R_RST term
  // keeps the memory port quiet even if the reset edge races the clock.
  assign w_accept     = R_INC & ~r_empty & R_RST;
  assign w_rbin_next  = r_rbin + {{ADDR_WIDTH{1'b0}}, w_accept};
  assign w_gnext      = (w_rbin_next >> 1) ^ w_rbin_next;
  assign w_wbin       = gray2bin(rq2_wptr);
  // Modulo subtraction; a full FIFO yields exactly 2^ADDR_WIDTH.
  assign w_level_next = w_wbin - w_rbin_next;

  // Read pointer and its Gray image. Gray changes one bit per increment,
  // so it is safe for the write-domain synchroniser.
  always_ff @(posedge R_CLK or negedge R_RST) begin
    if (!R_RST) begin
      r_rbin <= '0;
      r_ptr  <= '0;
    end else begin
      r_rbin <= w_rbin_next;
      r_ptr  <= w_gnext;
    end
  end

  // Status flags. Empty uses the look-ahead pointer, so the read that
  // drains the last word raises empty on that same edge.
  always_ff @(posedge R_CLK or negedge R_RST) begin
    if (!R_RST) begin
      r_empty     <= 1'b1;
      r_aempty    <= 1'b1;
      r_level     <= '0;
      r_valid     <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_empty     <= (w_gnext == rq2_wptr);
      r_aempty    <= (w_level_next <= AE_TH);
      r_level     <= w_level_next;
      r_valid     <= w_accept;
      // A new underflow takes priority over a clear in the same cycle.
      r_underflow <= (R_INC & r_empty) | (r_underflow & ~R_UF_CLR);
    end
  end

  assign R_ADDR      = r_rbin[ADDR_WIDTH-1:0];
  assign R_RD_EN     = w_accept;
  assign R_PTR       = r_ptr;
  assign R_EMPTY     = r_empty;
  assign R_AEMPTY    = r_aempty;
  assign R_LEVEL     = r_level;
  assign R_VALID     = r_valid;
  assign R_UNDERFLOW = r_underflow;

endmodule
